// File: rtl/intt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// intt : iterative inverse NTT, one Gentleman-Sande butterfly per cycle
// Rev 1.0
// ---------------------------------------------------------------------------
module intt #(
  parameter int P     = 17,
  parameter int N     = 8,
  parameter int W_INV = 9,
  parameter int N_INV = 15,
  parameter int LOGN  = $clog2(N),
  parameter int LOGP  = $clog2(P),
  parameter int NB    = N * LOGP
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          data_in_ready,
  input  logic [NB-1:0] poly_in,
  output logic          busy,
  output logic          done,
  output logic [NB-1:0] poly_out
);

  localparam int SW = (LOGN > 1) ? $clog2(LOGN) : 1;
  localparam int PW = LOGN - 1;

  localparam logic [LOGP-1:0]   c_P          = LOGP'(P);
  localparam logic [LOGP:0]     c_P_EXT      = (LOGP+1)'(P);
  localparam logic [2*LOGP-1:0] c_P_WIDE     = (2*LOGP)'(P);
  localparam logic [LOGP-1:0]   c_N_INV      = LOGP'(N_INV);
  localparam logic [SW-1:0]     c_LAST_STAGE = SW'(LOGN - 1);
  localparam logic [PW-1:0]     c_LAST_PAIR  = {PW{1'b1}};
  localparam logic [LOGN-1:0]   c_LAST_IDX   = {LOGN{1'b1}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    COMPUTE = 3'd2,
    SCALE   = 3'd3,
    FINISH  = 3'd4
  } state_t;

  function automatic int pow_mod(input int e);
    int r;
    r = 1;
    for (int k = 0; k < e; k++) r = (r * W_INV) % P;
    return r;
  endfunction

  function automatic logic [LOGP-1:0] mod_add(input logic [LOGP-1:0] a, input logic [LOGP-1:0] b);
    logic [LOGP:0] s;
    s = {1'b0, a} + {1'b0, b};
    return LOGP'((s >= c_P_EXT) ? s - c_P_EXT : s);
  endfunction

  // Bias by P first so the difference never goes negative.
  function automatic logic [LOGP-1:0] mod_sub(input logic [LOGP-1:0] a, input logic [LOGP-1:0] b);
    logic [LOGP:0] d;
    d = {1'b0, a} + c_P_EXT - {1'b0, b};
    return LOGP'((d >= c_P_EXT) ? d - c_P_EXT : d);
  endfunction

  function automatic logic [LOGP-1:0] mod_mul(input logic [LOGP-1:0] a, input logic [LOGP-1:0] b);
    logic [2*LOGP-1:0] t;
    t = {{LOGP{1'b0}}, a} * {{LOGP{1'b0}}, b};
    return LOGP'(t % c_P_WIDE);
  endfunction

  function automatic logic [LOGN-1:0] bit_rev(input logic [LOGN-1:0] i);
    logic [LOGN-1:0] r;
    for (int k = 0; k < LOGN; k++) r[k] = i[LOGN-1-k];
    return r;
  endfunction

  state_t          r_state;
  state_t          w_state_next;
  logic [SW-1:0]   r_stage;
  logic [PW-1:0]   r_pair;
  logic [LOGN-1:0] r_scale_idx;
  logic [LOGP-1:0] r_coef    [N];
  logic [LOGP-1:0] r_staging [N];

  logic [LOGP-1:0] w_tw_tab [N/2];
  logic [LOGP-1:0] w_load   [N];
  logic [NB-1:0]   w_staging_flat;

  generate
    for (genvar gi = 0; gi < N/2; gi++) begin : g_tw
      localparam logic [LOGP-1:0] c_TW = LOGP'(pow_mod(gi));
      assign w_tw_tab[gi] = c_TW;
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_load
      logic [LOGP-1:0] w_raw;
      assign w_raw      = poly_in[LOGP*gi +: LOGP];
      assign w_load[gi] = (w_raw >= c_P) ? w_raw - c_P : w_raw;
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
      assign w_staging_flat[LOGP*gi +: LOGP] = r_staging[gi];
    end
  endgenerate

  // Butterfly addressing: the pair index gets a zero bit inserted at the
  // half-span position to form the upper index; the twiddle exponent is the
  // offset within the block scaled by 2^stage.
  logic [PW-1:0]   w_mask;
  logic [PW-1:0]   w_j;
  logic [PW-1:0]   w_tw_idx;
  logic [LOGN-1:0] w_half;
  logic [LOGN-1:0] w_idx_u;
  logic [LOGN-1:0] w_idx_v;
  logic [LOGP-1:0] w_u;
  logic [LOGP-1:0] w_v;
  logic [LOGP-1:0] w_bf_sum;
  logic [LOGP-1:0] w_bf_prod;
  logic [LOGN-1:0] w_rev_idx;
  logic [LOGP-1:0] w_scaled;
  logic            w_last_pair;
  logic            w_last_stage;
  logic            w_last_idx;

  assign w_mask    = c_LAST_PAIR >> r_stage;
  assign w_j       = r_pair & w_mask;
  assign w_tw_idx  = w_j << r_stage;
  assign w_half    = {1'b0, w_mask} + LOGN'(1);
  assign w_idx_u   = {r_pair & ~w_mask, 1'b0} | {1'b0, w_j};
  assign w_idx_v   = w_idx_u | w_half;
  assign w_u       = r_coef[w_idx_u];
  assign w_v       = r_coef[w_idx_v];
  assign w_bf_sum  = mod_add(w_u, w_v);
  assign w_bf_prod = mod_mul(mod_sub(w_u, w_v), w_tw_tab[w_tw_idx]);

  // The butterfly network leaves results in bit-reversed order.
  assign w_rev_idx = bit_rev(r_scale_idx);
  assign w_scaled  = mod_mul(r_coef[w_rev_idx], c_N_INV);

  assign w_last_pair  = (r_pair == c_LAST_PAIR);
  assign w_last_stage = (r_stage == c_LAST_STAGE);
  assign w_last_idx   = (r_scale_idx == c_LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (data_in_ready) w_state_next = LOAD;
      LOAD:    w_state_next = COMPUTE;
      COMPUTE: if (w_last_pair && w_last_stage) w_state_next = SCALE;
      SCALE:   if (w_last_idx) w_state_next = FINISH;
      FINISH:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stage     <= '0;
      r_pair      <= '0;
      r_scale_idx <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      poly_out    <= '0;
    end else begin
      busy <= (w_state_next != IDLE);
      done <= (r_state == FINISH);
      if (r_state == FINISH) poly_out <= w_staging_flat;
      if (r_state == COMPUTE) begin
        if (w_last_pair) begin
          r_pair  <= '0;
          r_stage <= w_last_stage ? '0 : r_stage + SW'(1);
        end else begin
          r_pair  <= r_pair + PW'(1);
        end
      end
      if (r_state == SCALE) r_scale_idx <= w_last_idx ? '0 : r_scale_idx + LOGN'(1);
    end
  end

  // Coefficient storage carries no reset; it is fully rewritten in LOAD.
  always_ff @(posedge clk) begin
    if (r_state == LOAD) begin
      for (int i = 0; i < N; i++) r_coef[i] <= w_load[i];
    end else if (r_state == COMPUTE) begin
      r_coef[w_idx_u] <= w_bf_sum;
      r_coef[w_idx_v] <= w_bf_prod;
    end
    if (r_state == SCALE) r_staging[r_scale_idx] <= w_scaled;
  end

endmodule
`default_nettype wire

// File: tb/tb_intt.sv
`default_nettype none
// tb_intt : scoreboard bench for intt, directed vectors plus random vectors
// checked against a direct-summation inverse NTT model.
module tb_intt;

  localparam int P     = 17;
  localparam int N     = 8;
  localparam int W_INV = 9;
  localparam int N_INV = 15;
  localparam int LOGP  = $clog2(P);
  localparam int NB    = N * LOGP;
  localparam int LAT   = 2 + (N/2) * $clog2(N) + N;

  typedef int vec_t [N];

  logic          clk = 1'b0;
  logic          reset;
  logic          data_in_ready;
  logic [NB-1:0] poly_in;
  logic          busy;
  logic          done;
  logic [NB-1:0] poly_out;

  intt #(.P(P), .N(N), .W_INV(W_INV), .N_INV(N_INV)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in_ready(data_in_ready),
    .poly_in      (poly_in),
    .busy         (busy),
    .done         (done),
    .poly_out     (poly_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NB-1:0] q_exp[$];
  int            q_start[$];
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int pw(input int b, input int e);
    int r;
    r = 1;
    for (int k = 0; k < e; k++) r = (r * b) % P;
    return r;
  endfunction

  // a[j] = N_INV * sum_i x[i] * W_INV^(i*j) mod P
  function automatic logic [NB-1:0] ref_intt(input logic [NB-1:0] v);
    int            x [N];
    int            acc;
    logic [NB-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) x[i] = int'(v[i*LOGP +: LOGP]) % P;
    for (int j = 0; j < N; j++) begin
      acc = 0;
      for (int i = 0; i < N; i++) acc = (acc + x[i] * pw(W_INV, (i * j) % N)) % P;
      acc = (acc * N_INV) % P;
      r[j*LOGP +: LOGP] = LOGP'(acc);
    end
    return r;
  endfunction

  function automatic logic [NB-1:0] pack(input vec_t a);
    logic [NB-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*LOGP +: LOGP] = LOGP'(a[i]);
    return r;
  endfunction

  logic [NB-1:0] m_exp;
  int            m_st;

  always @(negedge clk) begin
    if (!reset && done) begin
      if (q_exp.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_done: got done=1 expected no pending transform (cycle %0d)", cyc);
      end else begin
        m_exp = q_exp.pop_front();
        m_st  = q_start.pop_front();
        chk("result", poly_out, m_exp);
        chk_int("latency", cyc - m_st, LAT);
      end
    end
  end

  task automatic start(input logic [NB-1:0] v, input logic [NB-1:0] e, output int st);
    poly_in       = v;
    data_in_ready = 1'b1;
    @(posedge clk);
    #1;
    data_in_ready = 1'b0;
    st = cyc;
    q_exp.push_back(e);
    q_start.push_back(st);
  endtask

  task automatic wait_done(input bit pulse, input int st);
    bit got;
    bit busy_ok;
    got     = 1'b0;
    busy_ok = 1'b1;
    for (int k = 0; k < LAT + 10; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (pulse) data_in_ready = ((cyc - st) == 4) || ((cyc - st) == 9);
    end
    data_in_ready = 1'b0;
    chk_int("done_seen", int'(got), 1);
    chk_int("busy_held", int'(busy_ok), 1);
    if (got) chk_int("busy_low_at_done", int'(busy), 0);
  endtask

  vec_t          dv;
  logic [NB-1:0] rv;
  int            st;

  initial begin
    reset         = 1'b1;
    data_in_ready = 1'b0;
    poly_in       = '0;
    repeat (3) @(negedge clk);
    chk_int("reset_busy", int'(busy), 0);
    chk_int("reset_done", int'(done), 0);
    chk("reset_poly_out", poly_out, '0);
    reset = 1'b0;
    @(negedge clk);

    dv = '{1, 0, 0, 0, 0, 0, 0, 0};
    start(pack(dv), pack('{15, 15, 15, 15, 15, 15, 15, 15}), st);
    wait_done(1'b0, st);

    dv = '{1, 1, 1, 1, 1, 1, 1, 1};
    start(pack(dv), pack('{1, 0, 0, 0, 0, 0, 0, 0}), st);
    wait_done(1'b0, st);

    dv = '{0, 1, 0, 0, 0, 0, 0, 0};
    start(pack(dv), pack('{15, 16, 8, 4, 2, 1, 9, 13}), st);
    wait_done(1'b0, st);

    dv = '{17, 0, 0, 0, 0, 0, 0, 0};
    start(pack(dv), pack('{0, 0, 0, 0, 0, 0, 0, 0}), st);
    wait_done(1'b0, st);

    dv = '{18, 0, 0, 0, 0, 0, 0, 0};
    start(pack(dv), pack('{15, 15, 15, 15, 15, 15, 15, 15}), st);
    wait_done(1'b0, st);

    // Requests during a transform must be ignored.
    for (int i = 0; i < N; i++) rv[i*LOGP +: LOGP] = LOGP'($urandom_range(0, 31));
    start(rv, ref_intt(rv), st);
    wait_done(1'b1, st);
    repeat (30) @(negedge clk);

    // Reset in the middle of COMPUTE abandons the transform.
    for (int i = 0; i < N; i++) rv[i*LOGP +: LOGP] = LOGP'($urandom_range(0, 31));
    start(rv, ref_intt(rv), st);
    while ((cyc - st) < 8) @(negedge clk);
    reset = 1'b1;
    #1;
    void'(q_exp.pop_back());
    void'(q_start.pop_back());
    chk_int("midreset_busy", int'(busy), 0);
    chk_int("midreset_done", int'(done), 0);
    chk("midreset_poly_out", poly_out, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (35) @(negedge clk);
    chk("after_reset_poly_out", poly_out, '0);
    chk_int("after_reset_busy", int'(busy), 0);

    for (int i = 0; i < N; i++) rv[i*LOGP +: LOGP] = LOGP'($urandom_range(0, 31));
    start(rv, ref_intt(rv), st);
    wait_done(1'b0, st);

    // Back-to-back random transforms, each started the cycle after FINISH.
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < N; i++) rv[i*LOGP +: LOGP] = LOGP'($urandom_range(0, 31));
      start(rv, ref_intt(rv), st);
      wait_done(1'b0, st);
    end

    repeat (30) @(negedge clk);
    chk_int("pending_results", q_exp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
